// File: rtl/vga_timing_pkg.sv
// Shared raster constants and coordinate type for the timing generator and every *_mapper stage.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_ACTIVE_DEF   = 640;
  localparam int unsigned H_FP_DEF       = 16;
  localparam int unsigned H_SYNC_DEF     = 96;
  localparam int unsigned H_BP_DEF       = 48;
  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned V_FP_DEF       = 10;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BP_DEF       = 33;
  localparam int unsigned SYNC_DELAY_DEF = 2;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sw, input int unsigned bp);
    return act + fp + sw + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sw, input int unsigned bp);
    return act + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Async-reset shift register; every stage resets to all-ones so delayed syncs read inactive.
module sync_delay_line #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_s;
      assign unused_s = clk_i ^ rst_i;
      assign q_o      = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '1;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing: DrawX/DrawY, active-video flag, delayed hs/vs and a frame strobe/counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic        vga_clk,
  input  logic        reset,
  output coord_t      DrawX,
  output coord_t      DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        sync,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam coord_t H_LAST   = coord_t'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam coord_t V_LAST   = coord_t'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t      h_cnt_q, h_cnt_d;
  coord_t      v_cnt_q, v_cnt_d;
  logic        blank_q, blank_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        h_wrap_s, v_wrap_s;
  logic [1:0]  sync_dly_s;

  // Flags are decoded from next-state counters so they register in step with DrawX/DrawY.
  always_comb begin
    h_wrap_s = (h_cnt_q == H_LAST);
    v_wrap_s = (v_cnt_q == V_LAST);
    h_cnt_d  = h_wrap_s ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d  = v_cnt_q;
    if (h_wrap_s) begin
      v_cnt_d = v_wrap_s ? 10'd0 : v_cnt_q + 10'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
    blank_d       = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    hsync_d       = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
    vsync_d       = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
    frame_start_d = h_wrap_s && v_wrap_s;
    frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      blank_q       <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Syncs trail the coordinates to line up with the mappers' registered RGB.
  sync_delay_line #(
    .WIDTH(2),
    .DEPTH(SYNC_DELAY)
  ) u_sync_dly (
    .clk_i(vga_clk),
    .rst_i(reset),
    .d_i  ({hsync_q, vsync_q}),
    .q_o  (sync_dly_s)
  );

  assign DrawX       = h_cnt_q;
  assign DrawY       = v_cnt_q;
  assign blank       = blank_q;
  assign hs          = sync_dly_s[1];
  assign vs          = sync_dly_s[0];
  assign sync        = 1'b0;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing (A), shrunken timing with delay 2 (B) and delay 0 (C).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic vga_clk;
  logic rst_ac, rst_b;
  int   checks = 0;
  int   failures = 0;

  coord_t x_a, y_a, x_b, y_b, x_c, y_c;
  logic bl_a, hs_a, vs_a, sy_a, fs_a;
  logic bl_b, hs_b, vs_b, sy_b, fs_b;
  logic bl_c, hs_c, vs_c, sy_c, fs_c;
  logic [15:0] fc_a, fc_b, fc_c;

  vga_timing_gen u_a (
    .vga_clk(vga_clk), .reset(rst_ac), .DrawX(x_a), .DrawY(y_a), .blank(bl_a), .hs(hs_a),
    .vs(vs_a), .sync(sy_a), .frame_start(fs_a), .frame_count(fc_a));

  // Small raster: H_TOTAL=25, V_TOTAL=19, one frame = 475 clocks.
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(12), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .SYNC_DELAY(2)) u_b (
    .vga_clk(vga_clk), .reset(rst_b), .DrawX(x_b), .DrawY(y_b), .blank(bl_b), .hs(hs_b),
    .vs(vs_b), .sync(sy_b), .frame_start(fs_b), .frame_count(fc_b));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(12), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .SYNC_DELAY(0)) u_c (
    .vga_clk(vga_clk), .reset(rst_ac), .DrawX(x_c), .DrawY(y_c), .blank(bl_c), .hs(hs_c),
    .vs(vs_c), .sync(sy_c), .frame_start(fs_c), .frame_count(fc_c));

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int   dut;  // 0 = u_a, 2 = u_c
    int   k;    // rising edges since reset release
    int   x;
    int   y;
    logic bl;
    logic hs;
    logic vs;
    logic fs;
    int   fc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int d, input int k, input int x, input int y, input logic bl,
                              input logic h, input logic v, input logic f, input int fc);
    vec_t r;
    r.dut = d; r.k = k; r.x = x; r.y = y; r.bl = bl; r.hs = h; r.vs = v; r.fs = f; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int k;
    int lowcnt, firstx, xbad, ybad, blbad;
    int vslow, vsfirst, fscnt, fsk, fc475;
    string tag;
    int ax, ay, afc;
    logic abl, ahs, avs, afs;

    vq.push_back(mk(0,    0,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,    0,   0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,   17,  17, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,   18,  18, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,   21,  21, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,   22,  22, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,   25,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,  349,  24, 13, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,  350,   0, 14, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    vq.push_back(mk(2,  400,   0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(2,  475,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1));
    vq.push_back(mk(2,  476,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1));
    vq.push_back(mk(0,  639, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(0,  640, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(0,  657, 657, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(0,  658, 658, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
    vq.push_back(mk(0,  753, 753, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0));
    vq.push_back(mk(0,  754, 754, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(0,  799, 799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(0,  800,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(0, 1458, 658, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
    vq.push_back(mk(0, 1554, 754, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0));
    vq.push_back(mk(0, 2399, 799, 2, 1'b0, 1'b1, 1'b1, 1'b0, 0));

    rst_ac = 1'b1;
    rst_b  = 1'b1;
    repeat (3) @(negedge vga_clk);
    chk("rst_drawx", int'(x_a), 0);
    chk("rst_drawy", int'(y_a), 0);
    chk("rst_blank", int'(bl_a), 1);
    chk("rst_hs", int'(hs_a), 1);
    chk("rst_vs", int'(vs_a), 1);
    chk("rst_sync", int'(sy_a), 0);
    chk("rst_fs", int'(fs_a), 0);
    chk("rst_fc", int'(fc_a), 0);

    rst_ac = 1'b0;
    k = 0;
    foreach (vq[i]) begin
      repeat (vq[i].k - k) @(negedge vga_clk);
      k = vq[i].k;
      if (vq[i].dut == 0) begin
        ax = int'(x_a); ay = int'(y_a); abl = bl_a; ahs = hs_a; avs = vs_a; afs = fs_a; afc = int'(fc_a);
      end else begin
        ax = int'(x_c); ay = int'(y_c); abl = bl_c; ahs = hs_c; avs = vs_c; afs = fs_c; afc = int'(fc_c);
      end
      tag = $sformatf("v%0d_k%0d", i, k);
      chk({tag, "_drawx"}, ax, vq[i].x);
      chk({tag, "_drawy"}, ay, vq[i].y);
      chk({tag, "_blank"}, int'(abl), int'(vq[i].bl));
      chk({tag, "_hs"}, int'(ahs), int'(vq[i].hs));
      chk({tag, "_vs"}, int'(avs), int'(vq[i].vs));
      chk({tag, "_fs"}, int'(afs), int'(vq[i].fs));
      chk({tag, "_fc"}, afc, vq[i].fc);
    end

    // One full line of the full-size raster against a counter model.
    lowcnt = 0; firstx = -1; xbad = 0; ybad = 0; blbad = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge vga_clk);
      k++;
      if (int'(x_a) != k % 800) xbad++;
      if (int'(y_a) != k / 800) ybad++;
      if (bl_a != ((k % 800) < 640)) blbad++;
      if (hs_a == 1'b0) begin
        lowcnt++;
        if (firstx < 0) firstx = int'(x_a);
      end
    end
    chk("line_drawx_errs", xbad, 0);
    chk("line_drawy_errs", ybad, 0);
    chk("line_blank_errs", blbad, 0);
    chk("line_hs_low_clocks", lowcnt, 96);
    chk("line_hs_first_low_x", firstx, 658);

    // Vertical sync and frame wrap on the small raster.
    @(negedge vga_clk);
    rst_b = 1'b0;
    k = 0; vslow = 0; vsfirst = -1; blbad = 0; fscnt = 0; fsk = -1; fc475 = -1;
    for (int i = 0; i < 476; i++) begin
      @(negedge vga_clk);
      k++;
      if (vs_b == 1'b0) begin
        vslow++;
        if (vsfirst < 0) vsfirst = k;
      end
      if ((int'(y_b) >= 12) && bl_b) blbad++;
      if (fs_b) begin
        fscnt++;
        fsk = k;
      end
      if (k == 475) fc475 = int'(fc_b);
    end
    chk("vs_low_clocks", vslow, 50);
    chk("vs_first_low_k", vsfirst, 352);
    chk("vblank_lines_blank", blbad, 0);
    chk("frame_pulse_count", fscnt, 1);
    chk("frame_pulse_k", fsk, 475);
    chk("frame_count_first", fc475, 1);

    force u_b.frame_count_q = 16'hFFFF;
    @(negedge vga_clk);
    k++;
    release u_b.frame_count_q;
    chk("fc_preload", int'(fc_b), 65535);
    repeat (950 - k) @(negedge vga_clk);
    k = 950;
    chk("wrap_fs", int'(fs_b), 1);
    chk("wrap_fc", int'(fc_b), 0);
    chk("wrap_drawx", int'(x_b), 0);
    chk("wrap_drawy", int'(y_b), 0);
    repeat (1425 - k) @(negedge vga_clk);
    k = 1425;
    chk("fc_after_wrap", int'(fc_b), 1);

    // Asynchronous reset mid-line while hs is low.
    repeat (1570 - k) @(negedge vga_clk);
    k = 1570;
    chk("pre_rst_drawx", int'(x_b), 20);
    chk("pre_rst_drawy", int'(y_b), 5);
    chk("pre_rst_hs", int'(hs_b), 0);
    #2 rst_b = 1'b1;
    #1;
    chk("async_drawx", int'(x_b), 0);
    chk("async_drawy", int'(y_b), 0);
    chk("async_blank", int'(bl_b), 1);
    chk("async_hs", int'(hs_b), 1);
    chk("async_vs", int'(vs_b), 1);
    chk("async_fs", int'(fs_b), 0);
    chk("async_fc", int'(fc_b), 0);
    repeat (2) @(negedge vga_clk);
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_rst_drawx_%0d", i), int'(x_b), i);
      chk($sformatf("post_rst_fs_%0d", i), int'(fs_b), 0);
      chk($sformatf("post_rst_hs_%0d", i), int'(hs_b), 1);
      chk($sformatf("post_rst_fc_%0d", i), int'(fc_b), 0);
      @(negedge vga_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
